// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared widths, vector/code types and FSM states for the irq collector
package irq_pkg;
    localparam int IRQ_N      = 8;
    localparam int IRQ_CODE_W = 3;

    typedef logic [IRQ_N-1:0]      irq_vec_t;
    typedef logic [IRQ_CODE_W-1:0] irq_code_t;

    typedef enum logic {
        IDLE,
        OFFER
    } irq_st_t;
endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-flop request synchroniser with one-cycle history for edge detection
module irq_sync #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq_in,
    output logic [N-1:0] s,
    output logic [N-1:0] rise
);
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
endmodule

// File: rtl/irq_pending_collector.sv
// rtl/irq_pending_collector.sv - sticky pending/mask front end of the priority encoder
// with a registered valid/ready request carrying the encoder's chosen index.
module irq_pending_collector
    import irq_pkg::*;
#(
    parameter int             N           = IRQ_N,
    parameter int             CODE_W      = IRQ_CODE_W,
    parameter int             SYNC_STAGES = 2,
    parameter bit             EDGE_MODE   = 1'b1,
    parameter logic [N-1:0]   MASK_RST    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      irq_in,
    input  logic              mask_wr,
    input  logic [N-1:0]      mask_data,
    output logic [N-1:0]      mask_q,
    output logic [N-1:0]      pending_q,
    output logic [N-1:0]      number,
    input  logic [CODE_W-1:0] code_in,
    output logic              req_valid,
    output logic [CODE_W-1:0] req_code,
    input  logic              req_ready
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]      s;
    logic [N-1:0]      rise;
    logic [N-1:0]      clr;
    logic [N-1:0]      pending_d;
    logic [N-1:0]      mask_d;
    irq_st_t           state_q, state_d;
    logic [CODE_W-1:0] req_code_q, req_code_d;
    logic              accept;

    irq_sync #(
        .N          (N),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .irq_in(irq_in),
        .s     (s),
        .rise  (rise)
    );

    assign accept = (state_q == OFFER) && req_ready;
    assign clr    = accept ? (ONE << req_code_q) : '0;

    // Set is OR-ed in after the clear so a new event on the serviced bit survives.
    always_comb begin
        pending_d = (pending_q & ~clr) | rise;
        if (!EDGE_MODE) begin
            pending_d = s;
        end
        mask_d = mask_wr ? mask_data : mask_q;
    end

    assign number = pending_q & ~mask_q;

    always_comb begin
        state_d    = state_q;
        req_code_d = req_code_q;
        case (state_q)
            IDLE: begin
                if (|number) begin
                    req_code_d = code_in;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            mask_q     <= MASK_RST;
            state_q    <= IDLE;
            req_code_q <= '0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            req_code_q <= req_code_d;
        end
    end

    assign req_valid = (state_q == OFFER);
    assign req_code  = req_code_q;
endmodule
